disp_link_sched: RTL and testbench

- Round-robin scheduler for the shared 32-bit display link, the pass-through connector that carries packed BCD digit words to the display drivers.
- Several sources compete for the link: timekeeping, alarm, stopwatch and set-mode.
- Each granted source owns the link for a fixed frame of HOLD cycles. Its word is snapshotted, so the link never carries a torn value.
- Sits between the clock-function blocks and the connector; the link outputs drive the connector inputs directly.

---
 rtl/disp_link_pkg.sv | 24 ++
 rtl/disp_link_sched_rr_pick.sv | 31 +++
 rtl/disp_link_sched.sv | 151 +++++++++++++++
 tb/tb_disp_link_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_link_pkg.sv
// Shared definitions for the display-link scheduler: default sizes, FSM
// encoding and small indexing helpers.
package disp_link_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Width of a source index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of source idx inside the packed data bus.
  function automatic int lane_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/disp_link_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module rr_pick
  import disp_link_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
        any_o                                = 1'b1;
        idx_o                                = IW'((int'(ptr_i) + k) % NREQ);
        onehot_o[(int'(ptr_i) + k) % NREQ]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_link_sched.sv
// Round-robin owner of the shared display link: each grant holds a snapshot
// word on the link for HOLD cycles, followed by GAP idle cycles.
module disp_link_sched
  import disp_link_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = 4,
  parameter int GAP   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [WIDTH-1:0]        link_data,
  output logic                    link_valid,
  output logic [idx_w(NREQ)-1:0]  link_src
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(HOLD + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, ptr_arb;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] link_data_q, link_data_d;
  logic             link_valid_q, link_valid_d;
  logic [IW-1:0]    link_src_q, link_src_d;

  logic [NREQ-1:0]  win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             frame_end;
  logic             arb_now;

  assign frame_end = (state_q == ST_HOLD) && (cnt_q == CW'(HOLD));

  // The pointer advances on the frame's last edge, so a back-to-back
  // arbitration on that same edge must already see the advanced value.
  always_comb begin
    ptr_arb = ptr_q;
    if (frame_end) begin
      ptr_arb = (link_src_q == IW'(NREQ - 1)) ? '0 : link_src_q + IW'(1);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_arb),
    .onehot_o (win_oh),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_arb;
    cnt_d        = cnt_q;
    gcnt_d       = gcnt_q;
    gnt_d        = gnt_q;
    done_d       = 1'b0;
    link_data_d  = link_data_q;
    link_valid_d = link_valid_q;
    link_src_d   = link_src_q;
    arb_now      = 1'b0;

    unique case (state_q)
      ST_IDLE: arb_now = 1'b1;
      ST_HOLD: begin
        if (frame_end) begin
          if (GAP > 0) begin
            state_d      = ST_GAP;
            gcnt_d       = GW'(1);
            gnt_d        = '0;
            link_valid_d = 1'b0;
          end else begin
            arb_now = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + CW'(1);
          done_d = (cnt_d == CW'(HOLD));
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP)) arb_now = 1'b1;
        else                    gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb_now) begin
      gcnt_d = '0;
      if (win_any) begin
        state_d      = ST_HOLD;
        gnt_d        = win_oh;
        link_src_d   = win_idx;
        link_data_d  = data[lane_lsb(int'(win_idx), WIDTH) +: WIDTH];
        link_valid_d = 1'b1;
        cnt_d        = CW'(1);
        done_d       = (HOLD == 1);
      end else begin
        state_d      = ST_IDLE;
        gnt_d        = '0;
        link_valid_d = 1'b0;
        cnt_d        = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      gcnt_q       <= '0;
      gnt_q        <= '0;
      done_q       <= 1'b0;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      link_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      gcnt_q       <= gcnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      link_data_q  <= link_data_d;
      link_valid_q <= link_valid_d;
      link_src_q   <= link_src_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign link_data  = link_data_q;
  assign link_valid = link_valid_q;
  assign link_src   = link_src_q;

endmodule

// File: tb/tb_disp_link_sched.sv
// Directed bench for disp_link_sched: a GAP=1 instance and a GAP=0 instance
// share clock and reset; each scenario task checks its own expectations.
module tb_disp_link_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;

  logic [NREQ-1:0]       req_a = '0;
  logic [NREQ*WIDTH-1:0] data_a = '0;
  logic [NREQ-1:0]       gnt_a;
  logic                  done_a;
  logic [WIDTH-1:0]      link_data_a;
  logic                  link_valid_a;
  logic [1:0]            link_src_a;

  logic [NREQ-1:0]       req_b = '0;
  logic [NREQ*WIDTH-1:0] data_b = '0;
  logic [NREQ-1:0]       gnt_b;
  logic                  done_b;
  logic [WIDTH-1:0]      link_data_b;
  logic                  link_valid_b;
  logic [1:0]            link_src_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  disp_link_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(4), .GAP(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .req        (req_a),
    .data       (data_a),
    .gnt        (gnt_a),
    .done       (done_a),
    .link_data  (link_data_a),
    .link_valid (link_valid_a),
    .link_src   (link_src_a)
  );

  disp_link_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(4), .GAP(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req        (req_b),
    .data       (data_b),
    .gnt        (gnt_b),
    .done       (done_b),
    .link_data  (link_data_b),
    .link_valid (link_valid_b),
    .link_src   (link_src_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_a = '0;
    req_b = '0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Checks one valid-or-idle cycle of instance A against hand-derived values.
  task automatic expect_a(input string tag, input logic v, input logic [3:0] g,
                          input logic [1:0] s, input logic [31:0] d, input logic dn);
    n_cmp++;
    if (link_valid_a !== v || gnt_a !== g || done_a !== dn ||
        (v && (link_src_a !== s || link_data_a !== d))) begin
      n_err++;
      $display("FAIL %s: got valid=%b gnt=%b src=%0d data=%h done=%b, want valid=%b gnt=%b src=%0d data=%h done=%b",
               tag, link_valid_a, gnt_a, link_src_a, link_data_a, done_a, v, g, s, d, dn);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (gnt_a !== 4'b0 || done_a !== 1'b0 || link_data_a !== 32'h0 ||
        link_valid_a !== 1'b0 || link_src_a !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b done=%b data=%h valid=%b src=%0d, want all zero",
               gnt_a, done_a, link_data_a, link_valid_a, link_src_a);
    end
    tick();
    tick();
    expect_a("idle_no_req", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic test_single();
    do_reset();
    data_a[31:0] = 32'h1234_5900;
    req_a        = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect_a($sformatf("single_hold%0d", k), 1'b1, 4'b0001, 2'd0, 32'h1234_5900, k == 4);
    end
    tick();
    expect_a("single_gap", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
    n_cmp++;
    if (link_data_a !== 32'h1234_5900) begin
      n_err++;
      $display("FAIL single_gap_hold_data: got %h want 12345900", link_data_a);
    end
    tick();
    expect_a("single_regrant", 1'b1, 4'b0001, 2'd0, 32'h1234_5900, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) data_a[i*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(i);
    req_a = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        expect_a($sformatf("rr_f%0d_c%0d", f, k), 1'b1, 4'b0001 << (f % 4),
                 2'(f % 4), 32'hA000_0000 + 32'(f % 4), k == 4);
      end
      tick();
      expect_a($sformatf("rr_f%0d_gap", f), 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    data_a[31:0] = 32'h1234_5900;
    req_a        = 4'b0001;
    tick();
    expect_a("snap_c1", 1'b1, 4'b0001, 2'd0, 32'h1234_5900, 1'b0);
    data_a[31:0] = 32'hFFFF_FFFF;
    for (int k = 2; k <= 4; k++) begin
      tick();
      expect_a($sformatf("snap_c%0d", k), 1'b1, 4'b0001, 2'd0, 32'h1234_5900, k == 4);
    end
    req_a = '0;
  endtask

  task automatic test_req_drop();
    do_reset();
    data_a[1*WIDTH +: WIDTH] = 32'h0000_0111;
    data_a[3*WIDTH +: WIDTH] = 32'h0000_0333;
    req_a = 4'b0010;
    tick();
    expect_a("drop_c1", 1'b1, 4'b0010, 2'd1, 32'h0000_0111, 1'b0);
    req_a = 4'b0000;
    for (int k = 2; k <= 4; k++) begin
      tick();
      expect_a($sformatf("drop_c%0d", k), 1'b1, 4'b0010, 2'd1, 32'h0000_0111, k == 4);
    end
    req_a = 4'b1010;
    tick();
    expect_a("drop_gap", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
    tick();
    expect_a("drop_ptr_src3", 1'b1, 4'b1000, 2'd3, 32'h0000_0333, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    data_a[0*WIDTH +: WIDTH] = 32'h0000_00A0;
    data_a[1*WIDTH +: WIDTH] = 32'h0000_00A1;
    req_a = 4'b0001;
    for (int k = 1; k <= 4; k++) tick();
    req_a = 4'b0011;
    tick();
    tick();
    expect_a("mid_src1_c1", 1'b1, 4'b0010, 2'd1, 32'h0000_00A1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (gnt_a !== 4'b0 || done_a !== 1'b0 || link_data_a !== 32'h0 ||
        link_valid_a !== 1'b0 || link_src_a !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset_clear: gnt=%b done=%b data=%h valid=%b src=%0d, want all zero",
               gnt_a, done_a, link_data_a, link_valid_a, link_src_a);
    end
    rst = 1'b0;
    tick();
    expect_a("mid_after_ptr0", 1'b1, 4'b0001, 2'd0, 32'h0000_00A0, 1'b0);
    req_a = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_b[0*WIDTH +: WIDTH] = 32'h1111_1111;
    data_b[1*WIDTH +: WIDTH] = 32'h2222_2222;
    req_b = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++;
      if (link_valid_b !== 1'b0 && k == 1) begin
        n_err++;
        $display("FAIL b2b_pre_valid: got %b want 0", link_valid_b);
      end
      tick();
      n_cmp++;
      if (link_valid_b !== 1'b1 || link_src_b !== 2'(((k - 1) / 4) % 2) ||
          gnt_b !== (4'b0001 << (((k - 1) / 4) % 2)) ||
          link_data_b !== ((((k - 1) / 4) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222) ||
          done_b !== (k % 4 == 0)) begin
        n_err++;
        $display("FAIL b2b_c%0d: got valid=%b src=%0d gnt=%b data=%h done=%b, want src=%0d done=%b",
                 k, link_valid_b, link_src_b, gnt_b, link_data_b, done_b,
                 ((k - 1) / 4) % 2, k % 4 == 0);
      end
    end
    req_b = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_snapshot();
    test_req_drop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
